// File: rtl/hwag_ign_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : hwag_ign_sched_if
// Description : Handshake bundle between the ignition scheduler and the
//               shared iterative divider. The scheduler is the master.
// Revision    : 1.0  initial release
// ============================================================================
interface hwag_ign_sched_if #(
  parameter int W = 24
) ();
  logic         div_start;
  logic [W-1:0] div_dividend;
  logic [W-1:0] div_divider;
  logic         div_rdy;
  logic [W-1:0] div_result;

  modport master (
    output div_start, div_dividend, div_divider,
    input  div_rdy, div_result
  );

  modport slave (
    input  div_start, div_dividend, div_divider,
    output div_rdy, div_result
  );
endinterface
`default_nettype wire

// File: rtl/hwag_ign_sched.sv
`default_nettype none
// ============================================================================
// Module      : hwag_ign_sched
// Description : Ignition channel scheduler. On each tick, sweeps all channels
//               through one shared divider to turn charge time into a delta
//               angle, then drives one coil output per channel from angle
//               compares (set at ang-delta, clear at ang, clear wins).
//               Optional macro HWAG_IGN_SCHED_SHADOW_EN: configuration writes
//               land in shadow registers copied at the start of each sweep.
//               The reset input rst is asynchronous and active-low.
// Revision    : 1.0  initial release
// ============================================================================
module hwag_ign_sched #(
  parameter int CH = 4,
  parameter int W  = 24
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          hwag_start,
  input  wire logic          tick,
  input  wire logic [W-1:0]  acnt,
  input  wire logic [W-1:0]  scnt_top,
  input  wire logic          cfg_we,
  input  wire logic [2:0]    cfg_ch,
  input  wire logic          cfg_sel,
  input  wire logic [W-1:0]  cfg_data,
  hwag_ign_sched_if.master   div,
  output logic [CH-1:0]      ign_out,
  output logic               busy,
  output logic               ovr
);

  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [CW-1:0] LAST_CH = CW'(CH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_LATCH = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] ch;
  logic [CW-1:0] ch_nxt;
  logic [W-1:0]  ang     [CH];
  logic [W-1:0]  chg     [CH];
  logic [W-1:0]  delta   [CH];
  logic [W-1:0]  set_ang [CH];
  logic [W-1:0]  div_top_q;
  logic [W-1:0]  dividend_q;
  logic [W-1:0]  result_q;
  logic          div_start_q;
  logic          sweep_go;
  logic          cfg_hit;
  logic [CW-1:0] cfg_idx;
  logic [W-1:0]  first_chg;

`ifdef HWAG_IGN_SCHED_SHADOW_EN
  logic [W-1:0]  sh_ang [CH];
  logic [W-1:0]  sh_chg [CH];
  assign first_chg = sh_chg[0];
`else
  assign first_chg = chg[0];
`endif

  assign sweep_go = (state == S_IDLE) && tick && hwag_start;
  assign cfg_hit  = cfg_we && (int'(cfg_ch) < CH);
  assign cfg_idx  = cfg_ch[CW-1:0];
  assign ch_nxt   = ch + CW'(1);

  // Divider operands are held in registers so a config write during WAIT
  // cannot disturb the operation in flight.
  assign div.div_start    = div_start_q;
  assign div.div_dividend = dividend_q;
  assign div.div_divider  = (div_top_q == {W{1'b1}}) ? {W{1'b1}} : div_top_q + W'(1);

  // Charge-start angle follows the live spark angle, modulo 2^W.
  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_set_ang
      assign set_ang[gi] = ang[gi] - delta[gi];
    end
  endgenerate

  // Configuration registers (direct, or shadowed and copied at sweep start).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CH; i++) begin
        ang[i] <= '0;
        chg[i] <= '0;
`ifdef HWAG_IGN_SCHED_SHADOW_EN
        sh_ang[i] <= '0;
        sh_chg[i] <= '0;
`endif
      end
    end else begin
`ifdef HWAG_IGN_SCHED_SHADOW_EN
      if (sweep_go) begin
        for (int i = 0; i < CH; i++) begin
          ang[i] <= sh_ang[i];
          chg[i] <= sh_chg[i];
        end
      end
      if (cfg_hit) begin
        if (cfg_sel) sh_chg[cfg_idx] <= cfg_data;
        else         sh_ang[cfg_idx] <= cfg_data;
      end
`else
      if (cfg_hit) begin
        if (cfg_sel) chg[cfg_idx] <= cfg_data;
        else         ang[cfg_idx] <= cfg_data;
      end
`endif
    end
  end

  // Sweep FSM: one divide per channel, outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      ch          <= '0;
      div_top_q   <= '0;
      dividend_q  <= '0;
      result_q    <= '0;
      div_start_q <= 1'b0;
      busy        <= 1'b0;
      ovr         <= 1'b0;
      for (int i = 0; i < CH; i++) delta[i] <= '0;
    end else begin
      div_start_q <= 1'b0;
      ovr         <= tick && (state != S_IDLE);
      if (!hwag_start) begin
        // Abandon the sweep; any divider result still in flight is ignored.
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (tick) begin
              div_top_q   <= scnt_top;
              ch          <= '0;
              dividend_q  <= first_chg;
              div_start_q <= 1'b1;
              busy        <= 1'b1;
              state       <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            state <= S_WAIT;
          end
          S_WAIT: begin
            if (div.div_rdy) begin
              result_q <= div.div_result;
              state    <= S_LATCH;
            end
          end
          S_LATCH: begin
            delta[ch] <= result_q;
            if (ch == LAST_CH) begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              ch          <= ch_nxt;
              dividend_q  <= chg[ch_nxt];
              div_start_q <= 1'b1;
              state       <= S_ISSUE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Coil drive: set on charge-start match, clear on spark match (clear wins).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ign_out <= '0;
    end else if (!hwag_start) begin
      ign_out <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (acnt == ang[i])          ign_out[i] <= 1'b0;
        else if (acnt == set_ang[i]) ign_out[i] <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
